instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request feeding a 2-entry {instruction, pc} FIFO.
// Optional misaligned-redirect fault detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [63:0] instr_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r, state_n_s;
    logic [63:0] fetch_pc_r, fetch_pc_n_s;
    logic [63:0] req_pc_r, req_pc_n_s;
    logic [31:0] ent0_instr_r, ent0_instr_n_s, ent1_instr_r, ent1_instr_n_s;
    logic [63:0] ent0_pc_r, ent0_pc_n_s, ent1_pc_r, ent1_pc_n_s;
    logic [1:0]  count_r, count_n_s;
    logic        fault_r, fault_n_s;
    logic        imem_req_r, imem_req_n_s;
    logic        instr_valid_r;
    logic        fire_s, push_s, pop_s;
    logic [63:0] redir_target_s;
    logic        redir_misaligned_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_target_s     = redirect_pc;
    assign redir_misaligned_s = (redirect_pc[1:0] != 2'b00);
`else
    // Without the check the low address bits are simply forced to word alignment.
    assign redir_target_s     = redirect_pc & ~64'd3;
    assign redir_misaligned_s = 1'b0;
`endif

    assign fire_s = imem_req_r & imem_gnt;
    assign push_s = (state_r == ST_WAIT) & imem_rvalid & ~redirect;
    assign pop_s  = instr_valid_r & instr_ready & ~redirect;

    // Next-state computation for the FSM, fetch pointers and FIFO contents.
    always_comb begin
        state_n_s      = state_r;
        fetch_pc_n_s   = fetch_pc_r;
        req_pc_n_s     = req_pc_r;
        ent0_instr_n_s = ent0_instr_r;
        ent0_pc_n_s    = ent0_pc_r;
        ent1_instr_n_s = ent1_instr_r;
        ent1_pc_n_s    = ent1_pc_r;
        count_n_s      = count_r;
        fault_n_s      = fault_r;
        if (redirect) begin
            fetch_pc_n_s = redir_target_s;
            fault_n_s    = redir_misaligned_s;
            count_n_s    = 2'd0;
            // A granted but unanswered request must have its response swallowed.
            case (state_r)
                ST_REQ:   state_n_s = fire_s ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_n_s = imem_rvalid ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_n_s = imem_rvalid ? ST_REQ : ST_DRAIN;
                default:  state_n_s = ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (fire_s) begin
                        req_pc_n_s   = fetch_pc_r;
                        fetch_pc_n_s = fetch_pc_r + 64'd4;
                        state_n_s    = ST_WAIT;
                    end else begin
                        state_n_s = ST_REQ;
                    end
                end
                ST_WAIT:  state_n_s = imem_rvalid ? ST_REQ : ST_WAIT;
                ST_DRAIN: state_n_s = imem_rvalid ? ST_REQ : ST_DRAIN;
                default:  state_n_s = ST_REQ;
            endcase
            // Entry 0 is always the head; entry 1 shifts down on a pop.
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        ent0_instr_n_s = imem_rdata;
                        ent0_pc_n_s    = req_pc_r;
                        count_n_s      = 2'd1;
                    end else if (count_r == 2'd1) begin
                        ent1_instr_n_s = imem_rdata;
                        ent1_pc_n_s    = req_pc_r;
                        count_n_s      = 2'd2;
                    end else begin
                        count_n_s = count_r;
                    end
                end
                2'b01: begin
                    ent0_instr_n_s = ent1_instr_r;
                    ent0_pc_n_s    = ent1_pc_r;
                    count_n_s      = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        ent0_instr_n_s = imem_rdata;
                        ent0_pc_n_s    = req_pc_r;
                    end else begin
                        ent0_instr_n_s = ent1_instr_r;
                        ent0_pc_n_s    = ent1_pc_r;
                        ent1_instr_n_s = imem_rdata;
                        ent1_pc_n_s    = req_pc_r;
                    end
                end
                default: count_n_s = count_r;
            endcase
        end
        imem_req_n_s = (state_n_s == ST_REQ) & (count_n_s < 2'd2) & ~fault_n_s;
    end

    // State registers; outputs are registered copies of the next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_REQ;
            fetch_pc_r    <= RESET_PC;
            req_pc_r      <= 64'd0;
            ent0_instr_r  <= 32'd0;
            ent0_pc_r     <= 64'd0;
            ent1_instr_r  <= 32'd0;
            ent1_pc_r     <= 64'd0;
            count_r       <= 2'd0;
            fault_r       <= 1'b0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            fetch_pc_r    <= fetch_pc_n_s;
            req_pc_r      <= req_pc_n_s;
            ent0_instr_r  <= ent0_instr_n_s;
            ent0_pc_r     <= ent0_pc_n_s;
            ent1_instr_r  <= ent1_instr_n_s;
            ent1_pc_r     <= ent1_pc_n_s;
            count_r       <= count_n_s;
            fault_r       <= fault_n_s;
            imem_req_r    <= imem_req_n_s;
            instr_valid_r <= (count_n_s != 2'd0);
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = fetch_pc_r;
    assign instr_valid = instr_valid_r;
    assign instruction = ent0_instr_r;
    assign instr_pc    = ent0_pc_r;
    assign fetch_fault = fault_r;

endmodule
